// File: rtl/firebird7_in_gate1_tessent_pkg.sv
// Shared types for the gate1 Tessent IJTAG TDRs: mux-control register layout and shift helper.
package firebird7_in_gate1_tessent_pkg;

  localparam int unsigned TDR_DATA_W = 19;

  typedef struct packed {
    logic                  sel;
    logic [TDR_DATA_W-1:0] data;
  } tdr_mux_ctl_t;

  // One scan step: si enters at the select end, data[0] falls off toward scan out.
  function automatic tdr_mux_ctl_t tdr_shift(input tdr_mux_ctl_t sr, input logic si);
    tdr_mux_ctl_t res;
    res.sel  = si;
    res.data = {sr.sel, sr.data[TDR_DATA_W-1:1]};
    return res;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_mux_ctl_w19.sv
// IJTAG TDR driving the gate1 19-bit data mux override (select + data).
// Build option FIREBIRD7_TDR_FUNC_CAPTURE_EN: capture observes functional_data_in instead of UR data.
module firebird7_in_gate1_tessent_tdr_mux_ctl_w19
  import firebird7_in_gate1_tessent_pkg::*;
#(
  parameter int unsigned           DATA_W   = TDR_DATA_W,
  parameter logic [DATA_W-1:0]     RST_DATA = '0,
  parameter logic                  RST_SEL  = 1'b0
) (
  input  logic              ijtag_tck,
  input  logic              ijtag_reset,
  input  logic              ijtag_sel,
  input  logic              ijtag_ce,
  input  logic              ijtag_se,
  input  logic              ijtag_ue,
  input  logic              ijtag_si,
  output logic              ijtag_so,
  input  logic [DATA_W-1:0] functional_data_in,
  output logic [DATA_W-1:0] ijtag_data_out,
  output logic              ijtag_select_out
);

  tdr_mux_ctl_t r_sr;
  tdr_mux_ctl_t r_ur;
  tdr_mux_ctl_t w_capture;

  // Select bit always reads back the update register so the override state stays observable.
  always_comb begin
    w_capture = r_ur;
`ifdef FIREBIRD7_TDR_FUNC_CAPTURE_EN
    w_capture.data = functional_data_in;
`endif
  end

`ifndef FIREBIRD7_TDR_FUNC_CAPTURE_EN
  logic w_unused_func_data;
  assign w_unused_func_data = ^functional_data_in;
`endif

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      r_sr <= '0;
    end else if (ijtag_sel) begin
      if (ijtag_ce) begin
        r_sr <= w_capture;
      end else if (ijtag_se) begin
        r_sr <= tdr_shift(r_sr, ijtag_si);
      end
    end
  end

  // Negedge update keeps the outputs stable across the whole posedge shift window.
  always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      r_ur <= {RST_SEL, RST_DATA};
    end else if (ijtag_sel && ijtag_ue) begin
      r_ur <= r_sr;
    end
  end

  assign ijtag_so         = r_sr.data[0];
  assign ijtag_data_out   = r_ur.data;
  assign ijtag_select_out = r_ur.sel;

endmodule
